addsub_pipe: RTL and testbench

Parametrised, pipelined signed/unsigned adder-subtractor with a valid/ready handshake at both ends. The carry chain is broken into CHUNK-bit slices with one register stage per slice, so WIDTH can grow without lengthening the critical path. It reports carry-out, carry-into-MSB and two's-complement overflow, and adds optional signed saturation. It is the arithmetic core for the datapath's wide add/sub operations.

---
 rtl/addsub_pkg.sv | 20 ++
 rtl/addsub_chunk.sv | 18 +
 rtl/addsub_pipe.sv | 160 ++++++++++++++++
 tb/tb_addsub_pipe.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared opcode encoding and decode helpers for the pipelined adder-subtractor.
package addsub_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_SUB  = 2'd1,
    OP_ADDS = 2'd2,
    OP_SUBS = 2'd3
  } op_t;

  // Bit 0 doubles as the operand-inversion select and the carry-in.
  function automatic logic is_sub(op_t op);
    return op inside {OP_SUB, OP_SUBS};
  endfunction

  function automatic logic is_sat(op_t op);
    return op inside {OP_ADDS, OP_SUBS};
  endfunction

endpackage

// File: rtl/addsub_chunk.sv
// CHUNK-bit combinational ripple slice; also exposes the carry into its top bit.
module addsub_chunk #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_top
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

  // Sum bit = a ^ b ^ carry_in, so the carry into the top bit falls out directly.
  assign c_top = s[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined add/sub with one register stage per CHUNK-bit carry slice and a
// valid/ready handshake at both ends; optional signed saturation at the tail.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_cmsb,
  output logic             out_ovf,
  output logic             out_sat
);

  localparam int unsigned STAGES = WIDTH / CHUNK;

  if ((WIDTH % CHUNK) != 0 || WIDTH < 2) begin : g_param_check
    $error("addsub_pipe: WIDTH must be a multiple of CHUNK and at least 2");
  end

  logic             en;
  logic             sub;
  logic             sat_op;
  logic [WIDTH-1:0] y_eff;

  logic [STAGES-1:0] valid_q, valid_d;

  logic [WIDTH-1:0] sum_q;
  logic             cout_q, cmsb_q, ovf_q, res_sat_q;

  assign sub    = is_sub(op_t'(in_op));
  assign sat_op = is_sat(op_t'(in_op));
  assign y_eff  = in_y ^ {WIDTH{sub}};

  // Whole pipe advances together; a full pipe drains and refills in one cycle.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  always_comb begin
    valid_d    = '0;
    valid_d[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      valid_d[k] = valid_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (en) begin
      valid_q <= valid_d;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operand bits not yet consumed when entering stage k.
    localparam int unsigned Rem = WIDTH - k * CHUNK;

    logic [Rem-1:0]           x_in, y_in;
    logic [(k+1)*CHUNK-1:0]   sum_w;
    logic                     c_in, v_in, sat_in, load;
    logic [CHUNK-1:0]         s;
    logic                     cout, c_top;

    if (k == 0) begin : g_head
      assign x_in   = in_x;
      assign y_in   = y_eff;
      assign c_in   = sub;
      assign v_in   = in_valid;
      assign sat_in = sat_op;
      assign sum_w  = s;
    end else begin : g_body
      assign x_in   = g_stage[k-1].g_skew.x_q;
      assign y_in   = g_stage[k-1].g_skew.y_q;
      assign c_in   = g_stage[k-1].g_skew.carry_q;
      assign v_in   = valid_q[k-1];
      assign sat_in = g_stage[k-1].g_skew.sat_op_q;
      assign sum_w  = {s, g_stage[k-1].g_skew.lo_q};
    end

    assign load = en && v_in;

    addsub_chunk #(
      .CHUNK(CHUNK)
    ) u_chunk (
      .a    (x_in[CHUNK-1:0]),
      .b    (y_in[CHUNK-1:0]),
      .cin  (c_in),
      .s    (s),
      .cout (cout),
      .c_top(c_top)
    );

    if (k < STAGES - 1) begin : g_skew
      logic [Rem-CHUNK-1:0]   x_q, y_q;
      logic [(k+1)*CHUNK-1:0] lo_q;
      logic                   carry_q, sat_op_q;
      logic                   unused_c_top;

      assign unused_c_top = c_top;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          x_q      <= '0;
          y_q      <= '0;
          lo_q     <= '0;
          carry_q  <= 1'b0;
          sat_op_q <= 1'b0;
        end else if (load) begin
          x_q      <= x_in[Rem-1:CHUNK];
          y_q      <= y_in[Rem-1:CHUNK];
          lo_q     <= sum_w;
          carry_q  <= cout;
          sat_op_q <= sat_in;
        end
      end
    end else begin : g_tail
      logic ovf, sat_now, x_sign;

      assign x_sign  = x_in[Rem-1];
      assign ovf     = cout ^ c_top;
      assign sat_now = sat_in && ovf;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sum_q     <= '0;
          cout_q    <= 1'b0;
          cmsb_q    <= 1'b0;
          ovf_q     <= 1'b0;
          res_sat_q <= 1'b0;
        end else if (load) begin
          // Clamp toward X's sign: positive X overflows up, negative X down.
          sum_q     <= sat_now ? {x_sign, {(WIDTH-1){~x_sign}}} : sum_w;
          cout_q    <= cout;
          cmsb_q    <= c_top;
          ovf_q     <= ovf;
          res_sat_q <= sat_now;
        end
      end
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_cmsb  = cmsb_q;
  assign out_ovf   = ovf_q;
  assign out_sat   = res_sat_q;

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe: directed cases on 8/4, then random sweeps on 8/4, 32/8 and 8/8.
module tb_addsub_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid [3];
  logic        out_ready[3];
  logic [31:0] in_x     [3];
  logic [31:0] in_y     [3];
  logic [1:0]  in_op    [3];
  logic        in_ready [3];
  logic        out_valid[3];
  logic        out_cout [3];
  logic        out_cmsb [3];
  logic        out_ovf  [3];
  logic        out_sat  [3];
  logic [31:0] out_sum  [3];
  logic [7:0]  sum_a, sum_c;
  logic [31:0] sum_b;

  addsub_pipe #(.WIDTH(8), .CHUNK(4)) u_dut_w8c4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_x(in_x[0][7:0]), .in_y(in_y[0][7:0]), .in_op(in_op[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_sum(sum_a),
    .out_cout(out_cout[0]), .out_cmsb(out_cmsb[0]), .out_ovf(out_ovf[0]), .out_sat(out_sat[0])
  );

  addsub_pipe #(.WIDTH(32), .CHUNK(8)) u_dut_w32c8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_x(in_x[1]), .in_y(in_y[1]), .in_op(in_op[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_sum(sum_b),
    .out_cout(out_cout[1]), .out_cmsb(out_cmsb[1]), .out_ovf(out_ovf[1]), .out_sat(out_sat[1])
  );

  addsub_pipe #(.WIDTH(8), .CHUNK(8)) u_dut_w8c8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_x(in_x[2][7:0]), .in_y(in_y[2][7:0]), .in_op(in_op[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_sum(sum_c),
    .out_cout(out_cout[2]), .out_cmsb(out_cmsb[2]), .out_ovf(out_ovf[2]), .out_sat(out_sat[2])
  );

  assign out_sum[0] = {24'd0, sum_a};
  assign out_sum[1] = sum_b;
  assign out_sum[2] = {24'd0, sum_c};

  int          checks   = 0;
  int          failures = 0;
  int          n_res    = 0;
  logic [63:0] exp_q[$];
  bit          prev_stall = 1'b0;
  logic [63:0] snap = '0;

  function automatic int width_of(input int i);
    return (i == 1) ? 32 : 8;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Packed view: {cout, cmsb, ovf, sat, sum[31:0]}.
  function automatic logic [63:0] observed(input int i);
    return {28'd0, out_cout[i], out_cmsb[i], out_ovf[i], out_sat[i], out_sum[i]};
  endfunction

  // Reference: plain integer arithmetic, overflow from signed range.
  function automatic logic [63:0] model(input int w, input logic [31:0] x, input logic [31:0] y,
                                        input logic [1:0] op);
    longint unsigned m, xs, ys, yy, full, low, res;
    longint          lim, sx, sy, sr;
    bit              is_s, cout, cmsb, ovf, sat;
    m    = (64'd1 << w) - 64'd1;
    xs   = 64'(x) & m;
    ys   = 64'(y) & m;
    is_s = op[0];
    yy   = is_s ? (~ys & m) : ys;
    full = xs + yy + 64'(is_s);
    res  = full & m;
    cout = full[w];
    low  = (xs & (m >> 1)) + (yy & (m >> 1)) + 64'(is_s);
    cmsb = low[w-1];
    lim  = longint'(64'd1 << (w - 1));
    sx   = (xs >= 64'(lim)) ? longint'(xs) - 2 * lim : longint'(xs);
    sy   = (ys >= 64'(lim)) ? longint'(ys) - 2 * lim : longint'(ys);
    sr   = is_s ? sx - sy : sx + sy;
    ovf  = (sr >= lim) || (sr < -lim);
    sat  = op[1] && ovf;
    if (sat) res = (sx < 0) ? 64'(lim) : 64'(lim - 1);
    return {28'd0, cout, cmsb, ovf, sat, res[31:0]};
  endfunction

  // Mix of corner operands (0, -1, min, max) and random values.
  function automatic logic [31:0] pick(input int w);
    logic [31:0] m;
    m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return m;
      2:       return (m >> 1) + 32'd1;
      3:       return m >> 1;
      default: return $urandom & m;
    endcase
  endfunction

  // One clock: drive, observe at negedge, score, advance to just after posedge.
  task automatic step(input int i, input bit v, input logic [31:0] x, input logic [31:0] y,
                      input logic [1:0] op, input bit rdy, output bit acc);
    logic [63:0] now;
    bit          stalled;
    in_valid[i]  = v;
    in_x[i]      = x;
    in_y[i]      = y;
    in_op[i]     = op;
    out_ready[i] = rdy;
    @(negedge clk);
    now     = observed(i);
    stalled = out_valid[i] && !rdy;
    if (stalled) begin
      check_eq("stall_in_ready", 64'(in_ready[i]), 64'd0);
      if (prev_stall) check_eq("stall_hold", now, snap);
    end
    prev_stall = stalled;
    snap       = now;
    if (out_valid[i] && rdy) begin
      check_eq("out_has_expect", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        check_eq($sformatf("result_dut%0d", i), now, exp_q.pop_front());
        n_res++;
      end
    end
    acc = v && in_ready[i];
    if (acc) exp_q.push_back(model(width_of(i), x, y, op));
    @(posedge clk);
    #1;
  endtask

  // Single beat on the 8/4 instance; flags are {cout, cmsb, ovf, sat}.
  task automatic directed(input string tag, input logic [7:0] x, input logic [7:0] y,
                          input logic [1:0] op, input logic [7:0] e_sum, input logic [3:0] e_flags);
    bit acc;
    int lat;
    step(0, 1'b1, {24'd0, x}, {24'd0, y}, op, 1'b1, acc);
    check_eq({tag, "_accept"}, 64'(acc), 64'd1);
    in_valid[0] = 1'b0;
    lat = 1;
    while (!out_valid[0] && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq({tag, "_latency"}, 64'(lat), 64'd2);
    check_eq({tag, "_sum"}, 64'(out_sum[0]), 64'(e_sum));
    check_eq({tag, "_flags"}, 64'({out_cout[0], out_cmsb[0], out_ovf[0], out_sat[0]}),
             64'(e_flags));
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int sent, cyc;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b0;
      in_x[i]      = '0;
      in_y[i]      = '0;
      in_op[i]     = '0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("rst_out_valid%0d", i), 64'(out_valid[i]), 64'd0);
      check_eq($sformatf("rst_outputs%0d", i), observed(i), 64'd0);
      check_eq($sformatf("rst_in_ready%0d", i), 64'(in_ready[i]), 64'd1);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    directed("add_127",    8'd100,  8'd27,  2'd0, 8'h7F, 4'b0000);
    directed("add_ovf",    8'd100,  8'd28,  2'd0, 8'h80, 4'b0110);
    directed("adds_sat",   8'd100,  8'd28,  2'd2, 8'h7F, 4'b0111);
    directed("sub_borrow", 8'd5,    8'd9,   2'd1, 8'hFC, 4'b0000);
    directed("subs_sat",   8'h80,   8'h01,  2'd3, 8'h80, 4'b1011);
    directed("adds_neg",   8'h80,   8'hFF,  2'd2, 8'h80, 4'b1011);
    directed("subs_pos",   8'h7F,   8'hFF,  2'd3, 8'h7F, 4'b0111);

    // Back-to-back stream with a 3-cycle output stall in the middle.
    exp_q.delete();
    n_res = 0;
    sent  = 0;
    cyc   = 0;
    prev_stall = 1'b0;
    while ((sent < 6 || exp_q.size() != 0) && cyc < 40) begin
      step(0, sent < 6, pick(8), pick(8), 2'($urandom_range(0, 3)), !(cyc >= 3 && cyc <= 5), acc);
      if (acc) sent++;
      cyc++;
    end
    check_eq("bp_results", 64'(n_res), 64'd6);

    // Reset while two beats are in flight.
    step(0, 1'b1, 32'd3, 32'd4, 2'd0, 1'b1, acc);
    step(0, 1'b1, 32'd5, 32'd6, 2'd0, 1'b1, acc);
    rst_n = 1'b0;
    #1;
    check_eq("rst_async_valid", 64'(out_valid[0]), 64'd0);
    check_eq("rst_async_sum", 64'(out_sum[0]), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    prev_stall = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step(0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b1, acc);
      check_eq("rst_no_stale", 64'(out_valid[0]), 64'd0);
    end
    directed("post_rst", 8'd7, 8'd8, 2'd0, 8'h0F, 4'b0000);

    // Random sweep with random bubbles and backpressure on each configuration.
    for (int i = 0; i < 3; i++) begin
      exp_q.delete();
      n_res = 0;
      sent  = 0;
      cyc   = 0;
      prev_stall = 1'b0;
      while (sent < 4000 && cyc < 20000) begin
        step(i, $urandom_range(0, 3) != 0, pick(width_of(i)), pick(width_of(i)),
             2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0, acc);
        if (acc) sent++;
        cyc++;
      end
      cyc = 0;
      while (exp_q.size() != 0 && cyc < 20) begin
        step(i, 1'b0, 32'd0, 32'd0, 2'd0, 1'b1, acc);
        cyc++;
      end
      check_eq($sformatf("sweep%0d_sent", i), 64'(sent), 64'd4000);
      check_eq($sformatf("sweep%0d_count", i), 64'(n_res), 64'(sent));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
